// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: accepts a word, serializes it into a bit-pattern detector and counts detector hits.
// Build option SEQ_DET_MSB_FIRST_EN: serialize MSB first (default LSB first).
module seq_det_scheduler #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8,
    parameter int LAT    = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              word_valid_in,
    output logic              word_ready_out,
    input  logic [WORD_W-1:0] word_data_in,
    output logic              det_din_out,
    output logic              det_vld_out,
    input  logic              det_dout_in,
    output logic [CNT_W-1:0]  hit_cnt_out,
    output logic              busy_out,
    output logic              done_out
);

    // state    | meaning
    // ST_IDLE  | waiting for a word, ready asserted
    // ST_SHIFT | driving one word bit per cycle into the detector
    // ST_DRAIN | waiting LAT cycles for the last hits to emerge
    // ST_DONE  | one-cycle done pulse, hit count final
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BCNT_W = $clog2(WORD_W);
    localparam int DCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q;
    logic [BCNT_W-1:0]   bit_cnt_q;
    logic [DCNT_W-1:0]   drain_cnt_q;
    logic [LAT-1:0]      vld_dly_q;
    logic [LAT-1:0]      vld_dly_d;
    logic                det_din_q;
    logic                det_vld_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic                done_q;

    logic                in_bit;
    logic [WORD_W-1:0]   in_rest;
    logic                sh_bit;
    logic [WORD_W-1:0]   sh_rest;

`ifdef SEQ_DET_MSB_FIRST_EN
    assign in_bit  = word_data_in[WORD_W-1];
    assign in_rest = {word_data_in[WORD_W-2:0], 1'b0};
    assign sh_bit  = shift_q[WORD_W-1];
    assign sh_rest = {shift_q[WORD_W-2:0], 1'b0};
`else
    assign in_bit  = word_data_in[0];
    assign in_rest = {1'b0, word_data_in[WORD_W-1:1]};
    assign sh_bit  = shift_q[0];
    assign sh_rest = {1'b0, shift_q[WORD_W-1:1]};
`endif

    assign word_ready_out = (state_q == ST_IDLE);
    assign busy_out       = (state_q != ST_IDLE);
    assign det_din_out    = det_din_q;
    assign det_vld_out    = det_vld_q;
    assign hit_cnt_out    = hit_cnt_q;
    assign done_out       = done_q;

    // Oldest tap lines up with the detector output for the bit driven LAT cycles earlier
    assign vld_dly_d = LAT'({vld_dly_q, det_vld_q});

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (word_valid_in) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_cnt_q == '0) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_cnt_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            vld_dly_q   <= '0;
            det_din_q   <= 1'b0;
            det_vld_q   <= 1'b0;
            hit_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            vld_dly_q <= vld_dly_d;

            if ((state_q == ST_SHIFT || state_q == ST_DRAIN) && vld_dly_q[LAT-1]
                && det_dout_in && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (word_valid_in) begin
                        shift_q   <= in_rest;
                        det_din_q <= in_bit;
                        det_vld_q <= 1'b1;
                        bit_cnt_q <= BCNT_W'(WORD_W - 1);
                        hit_cnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        det_din_q   <= 1'b0;
                        det_vld_q   <= 1'b0;
                        drain_cnt_q <= DCNT_W'(LAT - 1);
                    end else begin
                        det_din_q <= sh_bit;
                        shift_q   <= sh_rest;
                        bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                end
                default: begin
                    det_din_q <= 1'b0;
                    det_vld_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: directed words through a 1101 detector stand-in, checked against a word-level hit model.
module tb_seq_det_scheduler;
    localparam int WORD_W = 16;
    localparam int LAT    = 2;
    localparam int FRAME  = WORD_W + LAT + 2;

`ifdef SEQ_DET_MSB_FIRST_EN
    localparam int L_000B = 0;
    localparam int L_B6DB = 4;
    localparam int L_D000 = 1;
`else
    localparam int L_000B = 1;
    localparam int L_B6DB = 5;
    localparam int L_D000 = 0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        word_valid_in = 1'b0;
    logic [15:0] word_data_in = '0;
    logic        word_ready_out, det_din_out, det_vld_out, busy_out, done_out;
    logic [7:0]  hit_cnt_out;
    logic        rdy_s, din_s, vld_s, busy_s, done_s;
    logic [1:0]  hit_s;
    logic        det_dout = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    seq_det_scheduler #(.WORD_W(WORD_W), .CNT_W(8), .LAT(LAT)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .word_valid_in(word_valid_in),
        .word_ready_out(word_ready_out), .word_data_in(word_data_in),
        .det_din_out(det_din_out), .det_vld_out(det_vld_out), .det_dout_in(det_dout),
        .hit_cnt_out(hit_cnt_out), .busy_out(busy_out), .done_out(done_out));

    seq_det_scheduler #(.WORD_W(WORD_W), .CNT_W(2), .LAT(LAT)) dut_sat (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .word_valid_in(word_valid_in),
        .word_ready_out(rdy_s), .word_data_in(word_data_in),
        .det_din_out(din_s), .det_vld_out(vld_s), .det_dout_in(det_dout),
        .hit_cnt_out(hit_s), .busy_out(busy_s), .done_out(done_s));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [15:0] w, input int j);
`ifdef SEQ_DET_MSB_FIRST_EN
        return w[15-j];
`else
        return w[j];
`endif
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    // Detector stand-in: 1101 over the valid bit stream, hit visible LAT cycles after the sample edge
    logic [3:0] dh = '0;
    logic       dp1 = 1'b0;
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dh <= '0; dp1 <= 1'b0; det_dout <= 1'b0;
        end else begin
            det_dout <= dp1;
            dp1      <= det_vld_out && ({dh[2:0], det_din_out} == 4'b1101);
            if (det_vld_out) dh <= {dh[2:0], det_din_out};
        end
    end

    // Word-level model: m_c is the cycle index within a frame (0 = idle)
    int          m_c = 0;
    int          m_cnt = 0;
    int          m_last = 0;
    logic [15:0] m_word = '0;
    logic [2:0]  m_hist = '0;
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_c = 0; m_cnt = 0; m_last = 0; m_hist = '0;
        end else if (m_c == 0) begin
            if (word_valid_in) begin
                logic [3:0] h;
                m_c = 1; m_word = word_data_in; m_cnt = 0;
                for (int j = 0; j < WORD_W; j++) begin
                    h = {m_hist, bit_at(word_data_in, j)};
                    if (h == 4'b1101) m_cnt++;
                    m_hist = h[2:0];
                end
            end
        end else begin
            m_c++;
            if (m_c == FRAME) begin
                m_c = 0;
                m_last = m_cnt;
            end
        end
    end

    always @(negedge clk_in) begin
        if (m_c == 0) begin
            chk("ready_idle", int'(word_ready_out), 1);
            chk("busy_idle", int'(busy_out), 0);
            chk("vld_idle", int'(det_vld_out), 0);
            chk("din_idle", int'(det_din_out), 0);
            chk("done_idle", int'(done_out), 0);
            chk("hit_idle", int'(hit_cnt_out), m_last);
            chk("hit_sat_idle", int'(hit_s), sat3(m_last));
        end else begin
            chk("ready_busy", int'(word_ready_out), 0);
            chk("busy_busy", int'(busy_out), 1);
            chk("vld_frame", int'(det_vld_out), (m_c <= WORD_W) ? 1 : 0);
            chk("din_frame", int'(det_din_out), (m_c <= WORD_W) ? int'(bit_at(m_word, m_c - 1)) : 0);
            chk("done_frame", int'(done_out), (m_c == WORD_W + LAT + 1) ? 1 : 0);
            if (m_c == 1) chk("hit_cleared", int'(hit_cnt_out), 0);
            if (m_c == WORD_W + LAT + 1) begin
                chk("hit_done", int'(hit_cnt_out), m_cnt);
                chk("hit_sat_done", int'(hit_s), sat3(m_cnt));
            end
        end
    end

    task automatic do_reset();
        #1;
        word_valid_in = 1'b0;
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic wait_done(input string nm, input int exp_hits, input int exp_sat);
        int dc = 0, nv = 0, h = 0, hs = 0;
        for (int k = 1; k <= 40 && dc == 0; k++) begin
            @(negedge clk_in);
            if (det_vld_out) nv++;
            if (done_out) begin
                dc = k; h = int'(hit_cnt_out); hs = int'(hit_s);
            end
        end
        chk({nm, "_done_cycle"}, dc, WORD_W + LAT + 1);
        chk({nm, "_vld_cycles"}, nv, WORD_W);
        chk({nm, "_hits"}, h, exp_hits);
        chk({nm, "_hits_sat"}, hs, exp_sat);
    endtask

    task automatic run_word(input logic [15:0] w, input string nm, input int exp_hits, input int exp_sat);
        @(posedge clk_in); #2;
        word_valid_in = 1'b1; word_data_in = w;
        @(posedge clk_in); #2;
        word_valid_in = 1'b0;
        wait_done(nm, exp_hits, exp_sat);
    endtask

    initial begin
        int nlow, nd;
        do_reset();
        chk("rst_ready", int'(word_ready_out), 1);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_vld", int'(det_vld_out), 0);
        chk("rst_din", int'(det_din_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_hit", int'(hit_cnt_out), 0);

        do_reset();
        run_word(16'h000B, "single", L_000B, L_000B);

        do_reset();
        run_word(16'hB6DB, "overlap", L_B6DB, 3);

        // Backpressure: valid held high; the second word waits for ready
        do_reset();
        @(posedge clk_in); #2;
        word_valid_in = 1'b1; word_data_in = 16'hFFFF;
        @(posedge clk_in);
        nlow = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk_in);
            if (k < FRAME && !word_ready_out) nlow++;
            if (k == 5) word_data_in = 16'h000B;
            if (k == FRAME - 1) begin
                chk("bp_done", int'(done_out), 1);
                chk("bp_hits", int'(hit_cnt_out), 0);
            end
            if (k == FRAME) chk("bp_ready_back", int'(word_ready_out), 1);
        end
        chk("bp_ready_low_cycles", nlow, FRAME - 1);
        @(posedge clk_in); #2;
        word_valid_in = 1'b0;
        wait_done("bp_second", L_000B, L_000B);

        // Reset in the middle of SHIFT
        do_reset();
        @(posedge clk_in); #2;
        word_valid_in = 1'b1; word_data_in = 16'h000B;
        @(posedge clk_in); #2;
        word_valid_in = 1'b0;
        for (int k = 1; k <= 8; k++) @(negedge clk_in);
        #1 rst_n_in = 1'b0;
        #1;
        chk("mid_ready", int'(word_ready_out), 1);
        chk("mid_busy", int'(busy_out), 0);
        chk("mid_vld", int'(det_vld_out), 0);
        chk("mid_hit", int'(hit_cnt_out), 0);
        repeat (2) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (done_out) nd++;
        end
        chk("mid_no_done", nd, 0);
        chk("mid_hit_after", int'(hit_cnt_out), 0);

        do_reset();
        run_word(16'hD000, "order", L_D000, L_D000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
